zap_wb_pt_responder: RTL and testbench



---
 rtl/zap_wb_pt_responder_pkg.sv | 31 +++
 rtl/zap_ram_sel_1r1w.sv | 60 ++++++
 rtl/zap_wb_pt_responder.sv | 193 +++++++++++++++++++
 tb/tb_zap_wb_pt_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_wb_pt_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : zap_wb_pt_responder_pkg
// Description : Shared FSM encodings, counter width and log2 helper for the
//               page-table descriptor responder.
// Revision    : 1.0 - initial release
// ============================================================================
package zap_wb_pt_responder_pkg;

  // Responder FSM encodings
  localparam logic [1:0] PT_IDLE = 2'd0;
  localparam logic [1:0] PT_WAIT = 2'd1;
  localparam logic [1:0] PT_RESP = 2'd2;

  // Wait-state counter width; covers WAIT_STATES 0..15
  localparam int unsigned PT_CNT_W = 4;

  // Ceiling log2 with a fixed loop bound so it elaborates as a constant
  function automatic int unsigned zap_clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/zap_ram_sel_1r1w.sv
`default_nettype none
// ============================================================================
// Module      : zap_ram_sel_1r1w
// Description : Descriptor table RAM. One byte-enabled write port, one
//               full-word backdoor write port that overrides it on an address
//               collision, and a registered read with combinational address.
// Revision    : 1.0 - initial release
// ============================================================================
module zap_ram_sel_1r1w #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_adr,
  input  logic [3:0]    i_wr_sel,
  input  logic [31:0]   i_wr_dat,
  input  logic          i_bd_wen,
  input  logic [AW-1:0] i_bd_adr,
  input  logic [31:0]   i_bd_dat,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_adr,
  output logic [31:0]   o_rd_dat
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rd_dat;
  logic [3:0]  w_byte_we;
  logic        w_bd_hit;

  // Backdoor to the same word suppresses every Wishbone byte lane
  assign w_bd_hit = i_bd_wen && (i_bd_adr == i_wr_adr);

  for (genvar b = 0; b < 4; b++) begin : g_byte_we
    assign w_byte_we[b] = i_wr_en & i_wr_sel[b] & ~w_bd_hit;
  end

  // Write ports: byte lanes from the bus, full word from the backdoor
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_byte_we[b]) begin
        r_mem[i_wr_adr][8*b +: 8] <= i_wr_dat[8*b +: 8];
      end
    end
    if (i_bd_wen) begin
      r_mem[i_bd_adr] <= i_bd_dat;
    end
  end

  // Registered read; a same-edge write is not visible until the next read
  always_ff @(posedge i_clk) begin
    if (i_rd_en) begin
      r_rd_dat <= r_mem[i_rd_adr];
    end
  end

  assign o_rd_dat = r_rd_dat;

endmodule
`default_nettype wire

// File: rtl/zap_wb_pt_responder.sv
`default_nettype none
// ============================================================================
// Module      : zap_wb_pt_responder
// Description : Wishbone classic slave serving L1/L2 page-table descriptors
//               with a programmable number of wait states before ack/err.
// Revision    : 1.0 - initial release
// ============================================================================
module zap_wb_pt_responder
  import zap_wb_pt_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_4000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic                             i_wb_cyc,
  input  logic                             i_wb_stb,
  input  logic [31:0]                      i_wb_adr,
  input  logic                             i_wb_wen,
  input  logic [3:0]                       i_wb_sel,
  input  logic [31:0]                      i_wb_dat,
  output logic [31:0]                      o_wb_dat,
  output logic                             o_wb_ack,
  output logic                             o_wb_err,
  input  logic                             i_bd_wen,
  input  logic [zap_clog2(DEPTH_WORDS)-1:0] i_bd_adr,
  input  logic [31:0]                      i_bd_dat
);

  localparam int unsigned         AW         = zap_clog2(DEPTH_WORDS);
  localparam logic [32:0]         c_win_lo   = {1'b0, ADDR_BASE};
  localparam logic [32:0]         c_win_hi   = c_win_lo + 33'(DEPTH_WORDS * 4);
  localparam logic [AW-1:0]       c_base_idx = ADDR_BASE[AW+1:2];
  localparam logic [PT_CNT_W-1:0] c_wait     = PT_CNT_W'(WAIT_STATES);

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [PT_CNT_W-1:0] r_cnt;

  // Request captured in IDLE
  logic [AW-1:0] r_idx;
  logic          r_wen;
  logic [3:0]    r_sel;
  logic [31:0]   r_dat;
  logic          r_in_range;

  // Live decode of the bus
  logic          w_req;
  logic          w_in_range;
  logic [AW-1:0] w_idx;

  // Request fields seen at the RESP-entry edge (live when WAIT_STATES==0)
  logic          w_use_live;
  logic [AW-1:0] w_cur_idx;
  logic          w_cur_wen;
  logic [3:0]    w_cur_sel;
  logic [31:0]   w_cur_dat;
  logic          w_cur_in_range;

  // Next-cycle outputs and RAM controls
  logic        w_enter_resp;
  logic        w_ack_nxt;
  logic        w_err_nxt;
  logic        w_rd_nxt;
  logic        w_mem_we;
  logic        r_ack;
  logic        r_err;
  logic        r_rd_valid;
  logic [31:0] w_ram_rd;

  assign w_req      = i_wb_cyc & i_wb_stb;
  // Window bounds are word aligned, so the byte-lane bits cannot change the result
  assign w_in_range = ({1'b0, i_wb_adr} >= c_win_lo) && ({1'b0, i_wb_adr} < c_win_hi);
  assign w_idx      = i_wb_adr[AW+1:2] - c_base_idx;

  assign w_use_live     = (r_state == PT_IDLE);
  assign w_cur_idx      = w_use_live ? w_idx      : r_idx;
  assign w_cur_wen      = w_use_live ? i_wb_wen   : r_wen;
  assign w_cur_sel      = w_use_live ? i_wb_sel   : r_sel;
  assign w_cur_dat      = w_use_live ? i_wb_dat   : r_dat;
  assign w_cur_in_range = w_use_live ? w_in_range : r_in_range;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= PT_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: wait-state countdown, abort on cyc drop, single RESP cycle
  always_comb begin
    w_state_nxt = PT_IDLE;
    case (r_state)
      PT_IDLE: begin
        if (w_req) begin
          w_state_nxt = (c_wait == '0) ? PT_RESP : PT_WAIT;
        end
      end
      PT_WAIT: begin
        if (!i_wb_cyc) begin
          w_state_nxt = PT_IDLE;
        end else if (r_cnt == PT_CNT_W'(1)) begin
          w_state_nxt = PT_RESP;
        end else begin
          w_state_nxt = PT_WAIT;
        end
      end
      PT_RESP: begin
        w_state_nxt = PT_IDLE;
      end
      default: begin
        w_state_nxt = PT_IDLE;
      end
    endcase
  end

  // Output logic: decide ack/err/read/write for the RESP-entry edge
  always_comb begin
    w_enter_resp = (w_state_nxt == PT_RESP) && (r_state != PT_RESP);
    w_ack_nxt    = w_enter_resp & w_cur_in_range;
    w_err_nxt    = w_enter_resp & ~w_cur_in_range;
    w_rd_nxt     = w_ack_nxt & ~w_cur_wen;
    w_mem_we     = w_ack_nxt & w_cur_wen & i_reset_n;
  end

  // Wait counter: loaded on acceptance, counts down while waiting
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if ((r_state == PT_IDLE) && w_req) begin
      r_cnt <= c_wait;
    end else if (r_state == PT_WAIT) begin
      r_cnt <= i_wb_cyc ? (r_cnt - PT_CNT_W'(1)) : '0;
    end
  end

  // Request latch: bus changes after acceptance are ignored
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_idx      <= '0;
      r_wen      <= 1'b0;
      r_sel      <= '0;
      r_dat      <= '0;
      r_in_range <= 1'b0;
    end else if ((r_state == PT_IDLE) && w_req) begin
      r_idx      <= w_idx;
      r_wen      <= i_wb_wen;
      r_sel      <= i_wb_sel;
      r_dat      <= i_wb_dat;
      r_in_range <= w_in_range;
    end
  end

  // Registered handshake outputs, high only during the RESP cycle
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_ack      <= w_ack_nxt;
      r_err      <= w_err_nxt;
      r_rd_valid <= w_rd_nxt;
    end
  end

  zap_ram_sel_1r1w #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_ram (
    .i_clk    (i_clk),
    .i_wr_en  (w_mem_we),
    .i_wr_adr (w_cur_idx),
    .i_wr_sel (w_cur_sel),
    .i_wr_dat (w_cur_dat),
    .i_bd_wen (i_bd_wen),
    .i_bd_adr (i_bd_adr),
    .i_bd_dat (i_bd_dat),
    .i_rd_en  (w_rd_nxt),
    .i_rd_adr (w_cur_idx),
    .o_rd_dat (w_ram_rd)
  );

  assign o_wb_ack = r_ack;
  assign o_wb_err = r_err;
  // Read data is masked to zero outside a read acknowledge
  assign o_wb_dat = r_rd_valid ? w_ram_rd : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_zap_wb_pt_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_zap_wb_pt_responder
// Description : Self-checking bench; three responders with 1, 3 and 0 wait
//               states against a word-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zap_wb_pt_responder;

  localparam logic [31:0] BASE  = 32'h0000_4000;
  localparam int unsigned DEPTH = 1024;

  logic        clk;
  logic        rst_n;
  logic        cyc    [3];
  logic        stb    [3];
  logic        wen    [3];
  logic [31:0] adr    [3];
  logic [31:0] wdat   [3];
  logic [3:0]  sel    [3];
  logic [31:0] odat   [3];
  logic        ack    [3];
  logic        err    [3];
  logic        bd_wen [3];
  logic [9:0]  bd_adr [3];
  logic [31:0] bd_dat [3];

  logic [31:0] mem_m [3][DEPTH];
  int n_checks;
  int n_fail;

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int unsigned WS = (k == 0) ? 1 : ((k == 1) ? 3 : 0);
    zap_wb_pt_responder #(
      .DEPTH_WORDS (DEPTH),
      .ADDR_BASE   (BASE),
      .WAIT_STATES (WS)
    ) u_dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .i_wb_cyc  (cyc[k]),
      .i_wb_stb  (stb[k]),
      .i_wb_adr  (adr[k]),
      .i_wb_wen  (wen[k]),
      .i_wb_sel  (sel[k]),
      .i_wb_dat  (wdat[k]),
      .o_wb_dat  (odat[k]),
      .o_wb_ack  (ack[k]),
      .o_wb_err  (err[k]),
      .i_bd_wen  (bd_wen[k]),
      .i_bd_adr  (bd_adr[k]),
      .i_bd_dat  (bd_dat[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int k, input string tag);
    chk($sformatf("%s_ack%0d", tag, k), {31'b0, ack[k]}, 32'h0);
    chk($sformatf("%s_err%0d", tag, k), {31'b0, err[k]}, 32'h0);
    chk($sformatf("%s_dat%0d", tag, k), odat[k], 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input int k, input int idx, input logic [31:0] val);
    bd_wen[k] = 1'b1;
    bd_adr[k] = 10'(idx);
    bd_dat[k] = val;
    tick();
    bd_wen[k] = 1'b0;
    mem_m[k][idx] = val;
  endtask

  // One complete transfer; optional backdoor write lands on the RESP-entry edge
  task automatic xfer(input int k, input logic [31:0] a, input logic w, input logic [3:0] s,
                      input logic [31:0] d, input logic bd_on, input int bd_idx,
                      input logic [31:0] bd_val);
    int          ws;
    logic        inr;
    int          idx;
    logic [31:0] exp_rd;
    logic [31:0] merged;
    logic        hit;
    ws  = ws_of(k);
    inr = (a >= BASE) && (a < BASE + DEPTH * 4);
    idx = inr ? int'((a - BASE) >> 2) : 0;
    exp_rd = mem_m[k][idx];
    cyc[k] = 1'b1; stb[k] = 1'b1;
    adr[k] = a; wen[k] = w; sel[k] = s; wdat[k] = d;
    if (bd_on && ws == 0) begin
      bd_wen[k] = 1'b1; bd_adr[k] = 10'(bd_idx); bd_dat[k] = bd_val;
    end
    for (int c = 1; c <= ws + 2; c++) begin
      tick();
      bd_wen[k] = 1'b0;
      hit = (c == ws + 1);
      chk($sformatf("ack%0d_c%0d", k, c), {31'b0, ack[k]}, {31'b0, hit & inr});
      chk($sformatf("err%0d_c%0d", k, c), {31'b0, err[k]}, {31'b0, hit & ~inr});
      chk($sformatf("dat%0d_c%0d", k, c), odat[k], (hit && inr && !w) ? exp_rd : 32'h0);
      if (hit) begin
        cyc[k] = 1'b0; stb[k] = 1'b0;
      end else if (c <= ws) begin
        adr[k] = $urandom; wdat[k] = $urandom; sel[k] = 4'($urandom); wen[k] = 1'($urandom);
        if (bd_on && c == ws) begin
          bd_wen[k] = 1'b1; bd_adr[k] = 10'(bd_idx); bd_dat[k] = bd_val;
        end
      end
    end
    if (inr && w) begin
      merged = mem_m[k][idx];
      for (int b = 0; b < 4; b++) if (s[b]) merged[8*b +: 8] = d[8*b +: 8];
      mem_m[k][idx] = merged;
    end
    if (bd_on) mem_m[k][bd_idx] = bd_val;
  endtask

  task automatic rd(input int k, input logic [31:0] a);
    xfer(k, a, 1'b0, 4'hF, $urandom, 1'b0, 0, 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc[k] = 0; stb[k] = 0; wen[k] = 0; adr[k] = 0; wdat[k] = 0; sel[k] = 0;
      bd_wen[k] = 0; bd_adr[k] = 0; bd_dat[k] = 0;
    end
    repeat (3) tick();
    for (int k = 0; k < 3; k++) chk_idle(k, "reset");
    rst_n = 1'b1;

    // Preload every word of all three tables
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < 3; k++) begin
        bd_wen[k] = 1'b1; bd_adr[k] = 10'(i); bd_dat[k] = $urandom;
        mem_m[k][i] = bd_dat[k];
      end
      tick();
    end
    for (int k = 0; k < 3; k++) bd_wen[k] = 1'b0;

    // Directed read with one wait state
    bd_write(0, 5, 32'hDEAD_BEEF);
    repeat (4) tick();
    rd(0, 32'h0000_4014);

    // Byte-enable write merge, then read back
    bd_write(0, 2, 32'hAAAA_AAAA);
    xfer(0, 32'h0000_4008, 1'b1, 4'b0101, 32'h1122_3344, 1'b0, 0, 32'h0);
    rd(0, 32'h0000_4008);
    chk("merge_model", mem_m[0][2], 32'hAA22_AA44);

    // Out-of-window accesses: err, and no aliasing write into the table
    rd(0, 32'h0000_3FFC);
    rd(0, 32'h0000_5000);
    xfer(0, 32'h0000_5000, 1'b1, 4'hF, 32'h0BAD_0BAD, 1'b0, 0, 32'h0);
    xfer(0, 32'h0000_3FFC, 1'b1, 4'hF, 32'h0BAD_0BAD, 1'b0, 0, 32'h0);
    rd(0, 32'h0000_4000);
    rd(0, 32'h0000_4FFC);

    // Abort with three wait states: cyc dropped mid-wait
    bd_write(1, 9, 32'h5555_1234);
    cyc[1] = 1; stb[1] = 1; adr[1] = 32'h0000_4024; wen[1] = 1; sel[1] = 4'hF; wdat[1] = 32'hFFFF_0000;
    tick();
    chk_idle(1, "abort1");
    tick();
    chk_idle(1, "abort2");
    cyc[1] = 0; stb[1] = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_idle(1, "abort_after");
    end
    rd(1, 32'h0000_4024);

    // Zero wait states, four back-to-back reads
    for (int i = 0; i < 4; i++) bd_write(2, 100 + i, 32'hC0DE_0000 + 32'(i));
    for (int i = 0; i < 4; i++) rd(2, BASE + 32'((100 + i) * 4));

    // Backdoor/bus collisions on the RESP-entry edge
    xfer(0, 32'h0000_4040, 1'b1, 4'b0011, 32'h1234_5678, 1'b1, 16, 32'hB00D_B00D);
    rd(0, 32'h0000_4040);
    xfer(2, 32'h0000_4044, 1'b0, 4'hF, 32'h0, 1'b1, 17, 32'h7777_8888);
    rd(2, 32'h0000_4044);

    // Reset during WAIT: pending write must not commit
    bd_write(0, 7, 32'h0123_4567);
    cyc[0] = 1; stb[0] = 1; adr[0] = 32'h0000_401C; wen[0] = 1; sel[0] = 4'hF; wdat[0] = 32'h89AB_CDEF;
    tick();
    rst_n = 1'b0;
    tick();
    chk_idle(0, "rst_wait1");
    tick();
    chk_idle(0, "rst_wait2");
    cyc[0] = 0; stb[0] = 0; rst_n = 1'b1;
    tick();
    chk_idle(0, "rst_rel");
    rd(0, 32'h0000_401C);

    // Randomized traffic on all three responders
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 3; k++) begin
        logic [31:0] a;
        int          bi;
        if ($urandom_range(0, 7) == 0) begin
          a = $urandom_range(0, 1) ? (BASE - 32'(4 * $urandom_range(1, 16)))
                                   : (BASE + DEPTH * 4 + 32'(4 * $urandom_range(0, 16)));
        end else begin
          a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        end
        a = a | 32'($urandom_range(0, 3));
        bi = $urandom_range(0, 1) ? int'(((a - BASE) >> 2) & 32'h3FF) : $urandom_range(0, DEPTH - 1);
        if ($urandom_range(0, 7) == 0) bd_write(k, $urandom_range(0, DEPTH - 1), $urandom);
        xfer(k, a, 1'($urandom), 4'($urandom), $urandom,
             ($urandom_range(0, 5) == 0), bi, $urandom);
        if ($urandom_range(0, 1) == 1) rd(k, BASE + 32'(4 * bi));
        repeat ($urandom_range(0, 2)) tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
